hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the five-stage RISC-V core. Watches register indices and control bits in the D/E/M/W stages. Drives the stall and flush enables of the F, D/E, E/M and M/W pipeline registers and the E-stage operand forwarding selects. Also sequences multi-cycle data-memory accesses through a wait-state FSM with timeout, and keeps saturating stall and flush performance counters.

---
 rtl/hazard_pkg.sv | 34 +++
 rtl/hazard_ctrl_sat_counter.sv | 33 +++
 rtl/hazard_ctrl.sv | 156 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
//   - hazard_state_e : memory-sequencing FSM states
//   - FWD_*          : E-stage operand forwarding select encodings
//   - RESULT_MEM     : ResultSrc encoding that marks a load
//   - fwd_sel()      : forwarding select for one E-stage operand
package hazard_pkg;

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } hazard_state_e;

   localparam logic [1:0] FWD_RF     = 2'b00;
   localparam logic [1:0] FWD_W      = 2'b01;
   localparam logic [1:0] FWD_M      = 2'b10;
   localparam logic [1:0] RESULT_MEM = 2'b01;

   // M is the younger producer, so it wins over W. x0 is never forwarded.
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] rs,
      input logic       reg_write_m,
      input logic [4:0] rd_m,
      input logic       reg_write_w,
      input logic [4:0] rd_w
   );
      if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs))
         return FWD_M;
      else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs))
         return FWD_W;
      else
         return FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: saturating up-counter.
//   clk_i   : clock
//   rst_i   : synchronous active-high clear
//   en_i    : increment this cycle
//   count_o : current count, sticks at all-ones
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (en_i && (count_q != '1))
         count_d = count_q + WIDTH'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard detection, forwarding and memory wait-state sequencing
// for the five-stage pipeline.
//   Inputs : register indices and control bits of D/E/M/W, PCSrcE,
//            MemReqM/MemReadyM handshake from data memory.
//   Outputs: StallF/D/E/M, FlushD/E/W pipeline-register enables,
//            ForwardAE/BE operand selects, sticky MemErr,
//            StallCycles/FlushCycles saturating counters,
//            dbg_state_o exposing the memory FSM state.
// Handshake: an M-stage access is requested by MemReqM and completes in the
// first cycle MemReadyM is high; the M instruction is held (with the younger
// stages) until then or until the wait counter expires.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [4:0]           Rs1D,
   input  logic [4:0]           Rs2D,
   input  logic [4:0]           Rs1E,
   input  logic [4:0]           Rs2E,
   input  logic [4:0]           RdE,
   input  logic [4:0]           RdM,
   input  logic [4:0]           RdW,
   input  logic [1:0]           ResultSrcE,
   input  logic                 RegWriteM,
   input  logic                 RegWriteW,
   input  logic                 PCSrcE,
   input  logic                 MemReqM,
   input  logic                 MemReadyM,
   output logic                 StallF,
   output logic                 StallD,
   output logic                 StallE,
   output logic                 StallM,
   output logic                 FlushD,
   output logic                 FlushE,
   output logic                 FlushW,
   output logic [1:0]           ForwardAE,
   output logic [1:0]           ForwardBE,
   output logic                 MemErr,
   output logic [CNT_WIDTH-1:0] StallCycles,
   output logic [CNT_WIDTH-1:0] FlushCycles,
   output hazard_state_e        dbg_state_o
);

   localparam int WCW = $clog2(MEM_TIMEOUT);

   hazard_state_e  state_q, state_d;
   logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
   logic           mem_err_q, mem_err_d;

   logic timeout;
   logic mem_stall;
   logic lw_stall;

   assign timeout   = (state_q == MEM_WAIT) && !MemReadyM &&
                      (wait_cnt_q == WCW'(MEM_TIMEOUT - 1));
   assign mem_stall = ((state_q == RUN) && MemReqM && !MemReadyM) ||
                      ((state_q == MEM_WAIT) && !MemReadyM && !timeout);
   assign lw_stall  = (ResultSrcE == RESULT_MEM) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

   // Pipeline-register enables. A memory stall freezes everything up to M,
   // which also holds back a pending branch flush or load-use bubble in E
   // until the wait ends.
   always_comb begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      FlushW    = 1'b0;
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
      if (rst) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
         FlushW = 1'b1;
      end else begin
         ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
         ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
         if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
         end else begin
            StallF = lw_stall;
            StallD = lw_stall;
            FlushE = lw_stall | PCSrcE;
            FlushD = PCSrcE;
            // An abandoned access retires as a bubble.
            FlushW = timeout;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      mem_err_d  = mem_err_q;
      case (state_q)
         RUN: begin
            if (MemReqM && !MemReadyM) begin
               state_d    = MEM_WAIT;
               wait_cnt_d = '0;
            end
         end
         MEM_WAIT: begin
            if (MemReadyM) begin
               state_d = RUN;
            end else if (timeout) begin
               state_d   = RUN;
               mem_err_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + WCW'(1);
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
         mem_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         mem_err_q  <= mem_err_d;
      end
   end

   assign MemErr      = mem_err_q;
   assign dbg_state_o = state_q;

   sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
      .clk_i   (clk),
      .rst_i   (rst),
      .en_i    (StallF),
      .count_o (StallCycles)
   );

   sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
      .clk_i   (clk),
      .rst_i   (rst),
      .en_i    (FlushE),
      .count_o (FlushCycles)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MEM_TIMEOUT = 4 and CNT_WIDTH = 3.
module tb_hazard_ctrl;
   import hazard_pkg::*;

   localparam int MEM_TIMEOUT = 4;
   localparam int CNT_WIDTH   = 3;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [4:0]           Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic [1:0]           ResultSrcE;
   logic                 RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
   logic                 StallF, StallD, StallE, StallM;
   logic                 FlushD, FlushE, FlushW;
   logic [1:0]           ForwardAE, ForwardBE;
   logic                 MemErr;
   logic [CNT_WIDTH-1:0] StallCycles, FlushCycles;
   hazard_state_e        dbg_state;

   int n_total = 0;
   int n_bad   = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_WIDTH(CNT_WIDTH)) dut (
      .clk(clk), .rst(rst),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
      .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
      .MemReqM(MemReqM), .MemReadyM(MemReadyM),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MemErr(MemErr),
      .StallCycles(StallCycles), .FlushCycles(FlushCycles),
      .dbg_state_o(dbg_state)
   );

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic clear_inputs();
      Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0;
      RdE = 0; RdM = 0; RdW = 0; ResultSrcE = 2'b00;
      RegWriteM = 0; RegWriteW = 0; PCSrcE = 0; MemReqM = 0; MemReadyM = 0;
   endtask

   // Advance past the next rising edge; inputs are then changed away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   // Check the seven enables as one packed vector {StallF,D,E,M,FlushD,E,W}.
   task automatic chk_ctl(input string tag, input logic [6:0] exp);
      chk(tag, {25'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW},
          {25'd0, exp});
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      clear_inputs();
      rst = 1'b1;
      tick();
      settle();

      // Reset: flushes asserted, no stalls, no forwarding.
      RegWriteM = 1; RdM = 5; Rs1E = 5;
      settle();
      chk_ctl("rst_ctl", 7'b0000_111);
      chk("rst_fwdA", 32'(ForwardAE), 32'(FWD_RF));
      tick();
      rst = 1'b0;
      clear_inputs();
      settle();
      chk("rst_state", 32'(dbg_state), 32'(RUN));
      chk("rst_err", 32'(MemErr), 0);
      chk("rst_scnt", 32'(StallCycles), 0);
      chk("rst_fcnt", 32'(FlushCycles), 0);
      chk_ctl("idle_ctl", 7'b0000_000);

      // Forwarding: M beats W.
      RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; Rs1E = 5; Rs2E = 5;
      settle();
      chk("fwd_m_prio_A", 32'(ForwardAE), 32'(FWD_M));
      chk("fwd_m_prio_B", 32'(ForwardBE), 32'(FWD_M));
      RdM = 0;
      settle();
      chk("fwd_w_A", 32'(ForwardAE), 32'(FWD_W));
      RdM = 5; RegWriteM = 0;
      settle();
      chk("fwd_m_nowrite", 32'(ForwardAE), 32'(FWD_W));
      RegWriteM = 1; RdM = 0; RdW = 0; Rs1E = 0; Rs2E = 3;
      settle();
      chk("fwd_x0", 32'(ForwardAE), 32'(FWD_RF));
      RdW = 3;
      settle();
      chk("fwd_w_B", 32'(ForwardBE), 32'(FWD_W));
      chk("fwd_x0_A_again", 32'(ForwardAE), 32'(FWD_RF));
      clear_inputs();

      // Load-use: exactly one bubble.
      ResultSrcE = RESULT_MEM; RdE = 7; Rs2D = 7;
      settle();
      chk_ctl("lw_ctl", 7'b1100_010);
      tick();
      ResultSrcE = 2'b00; RdE = 0; Rs2D = 0;
      RegWriteM = 1; RdM = 7; Rs2E = 7;
      settle();
      chk_ctl("lw_after_ctl", 7'b0000_000);
      chk("lw_after_fwdB", 32'(ForwardBE), 32'(FWD_M));
      chk("lw_scnt", 32'(StallCycles), 1);
      chk("lw_fcnt", 32'(FlushCycles), 1);
      clear_inputs();
      ResultSrcE = RESULT_MEM; RdE = 0; Rs1D = 0;
      settle();
      chk_ctl("lw_x0_ctl", 7'b0000_000);
      clear_inputs();

      // Taken branch.
      PCSrcE = 1;
      settle();
      chk_ctl("br_ctl", 7'b0000_110);
      tick();
      PCSrcE = 0;
      settle();
      chk("br_fcnt", 32'(FlushCycles), 2);
      chk_ctl("br_after_ctl", 7'b0000_000);

      // Memory wait: three not-ready cycles, branch pending meanwhile.
      MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk_ctl($sformatf("mw_stall%0d", i), 7'b1111_001);
         if (i > 0) chk($sformatf("mw_state%0d", i), 32'(dbg_state), 32'(MEM_WAIT));
         tick();
      end
      MemReadyM = 1;
      settle();
      chk_ctl("mw_release", 7'b0000_110);
      tick();
      clear_inputs();
      settle();
      chk("mw_state_back", 32'(dbg_state), 32'(RUN));
      chk("mw_scnt", 32'(StallCycles), 4);
      chk("mw_fcnt", 32'(FlushCycles), 3);
      chk("mw_err", 32'(MemErr), 0);

      // Zero-wait access.
      MemReqM = 1; MemReadyM = 1;
      settle();
      chk_ctl("zw_ctl", 7'b0000_000);
      tick();
      clear_inputs();
      settle();
      chk("zw_state", 32'(dbg_state), 32'(RUN));

      // Timeout: four stall cycles, then a bubble-retire cycle.
      MemReqM = 1; MemReadyM = 0;
      for (int i = 0; i < 4; i++) begin
         settle();
         chk_ctl($sformatf("to_stall%0d", i), 7'b1111_001);
         tick();
      end
      settle();
      chk_ctl("to_release", 7'b0000_001);
      chk("to_state_rel", 32'(dbg_state), 32'(MEM_WAIT));
      tick();
      clear_inputs();
      settle();
      chk("to_state_back", 32'(dbg_state), 32'(RUN));
      chk("to_err", 32'(MemErr), 1);
      chk("to_scnt_sat", 32'(StallCycles), 7);
      tick();
      settle();
      chk("to_err_sticky", 32'(MemErr), 1);

      // Saturation from a clean start.
      do_reset();
      settle();
      chk("sat_err_clr", 32'(MemErr), 0);
      ResultSrcE = RESULT_MEM; RdE = 7; Rs1D = 7;
      for (int i = 0; i < 10; i++) tick();
      clear_inputs();
      settle();
      chk("sat_scnt", 32'(StallCycles), 7);
      chk("sat_fcnt", 32'(FlushCycles), 7);

      // Reset in the middle of a wait.
      MemReqM = 1; MemReadyM = 0;
      tick();
      tick();
      settle();
      chk("rw_state_pre", 32'(dbg_state), 32'(MEM_WAIT));
      rst = 1'b1;
      settle();
      chk_ctl("rw_rst_ctl", 7'b0000_111);
      tick();
      rst = 1'b0;
      clear_inputs();
      settle();
      chk("rw_state", 32'(dbg_state), 32'(RUN));
      chk("rw_scnt", 32'(StallCycles), 0);
      chk("rw_fcnt", 32'(FlushCycles), 0);
      chk("rw_err", 32'(MemErr), 0);

      // ---------------- report ----------------
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   // Global bound so the bench cannot hang.
   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
